// File: rtl/keypad_matrix_scanner_pkg.sv
// keypad_pkg: shared constants and helpers for the 4x4 keypad matrix scanner.
//   - Matrix geometry (rows, columns, key-code width)
//   - FSM state encoding
//   - Row priority encoder and column drive helpers
package keypad_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;
    localparam int CODE_W = 4;

    // FSM state encoding
    localparam logic [1:0] SCAN      = 2'd0;
    localparam logic [1:0] DEB_PRESS = 2'd1;
    localparam logic [1:0] HELD      = 2'd2;

    // Lowest active row wins when several rows read active at once.
    function automatic logic [1:0] row_priority(input logic [N_ROWS-1:0] act);
        logic [1:0] sel;
        casez (act)
            4'b???1: sel = 2'd0;
            4'b??10: sel = 2'd1;
            4'b?100: sel = 2'd2;
            4'b1000: sel = 2'd3;
            default: sel = 2'd0;
        endcase
        return sel;
    endfunction

    // Active-low one-hot-zero column drive for a given column index.
    function automatic logic [N_COLS-1:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_strobe_gen.sv
// keypad_strobe_gen: free-running scan strobe generator.
//   Emits a one-cycle strobe every 2^scan_divider clock cycles. The strobe is
//   high during the cycle in which the counter holds all-ones, so the first
//   strobe appears 2^scan_divider - 1 cycles after reset release.
// Ports:
//   clock   in  system clock
//   reset_n in  asynchronous active-low reset
//   strobe  out one-cycle scan strobe (registered)
module keypad_strobe_gen #(
    parameter int scan_divider = 16
) (
    input  logic clock,
    input  logic reset_n,
    output logic strobe
);
    import keypad_pkg::*;

    // Counter value one cycle before all-ones; lets the strobe be registered
    // while still coinciding with the all-ones count.
    localparam logic [scan_divider-1:0] PRE_LAST = {{(scan_divider-1){1'b1}}, 1'b0};
    localparam logic [scan_divider-1:0] ONE      = {{(scan_divider-1){1'b0}}, 1'b1};

    logic [scan_divider-1:0] count_r;
    logic                    strobe_r;

    // Free-running period counter and registered strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r  <= '0;
            strobe_r <= 1'b0;
        end else begin
            count_r  <= count_r + ONE;
            strobe_r <= (count_r == PRE_LAST);
        end
    end

    assign strobe = strobe_r;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x4 membrane keypad scanner with debounce.
//   Drives one column low per scan period, reads the rows back through a
//   2-FF synchronizer, debounces press and release over debounce_strobes
//   consecutive samples and reports each confirmed press.
// Ports:
//   clock       in  system clock (50 MHz)
//   reset_n     in  asynchronous active-low reset
//   rows_in     in  keypad rows, active low, asynchronous
//   cols_out    out column drive, active low, one-hot-zero
//   key_code    out last confirmed key, col*4 + row
//   key_valid   out one-cycle pulse on a confirmed press
//   key_pressed out high while a confirmed key is held
module keypad_matrix_scanner #(
    parameter int scan_divider     = 16,
    parameter int debounce_strobes = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [3:0]          rows_in,
    output logic [3:0]          cols_out,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_pressed
);
    import keypad_pkg::*;

    localparam logic [3:0] DEB_LIMIT = 4'(debounce_strobes);

    logic                strobe_s;
    logic [N_ROWS-1:0]   sync_meta_r;
    logic [N_ROWS-1:0]   sync_r;
    logic [N_ROWS-1:0]   row_act_s;
    logic [1:0]          row_sel_s;
    logic                cand_hit_s;
    logic [3:0]          count_inc_s;
    logic [1:0]          col_next_s;

    logic [1:0]          state_r;
    logic [1:0]          col_r;
    logic [3:0]          count_r;
    logic [CODE_W-1:0]   cand_code_r;
    logic [N_COLS-1:0]   cols_out_r;
    logic [CODE_W-1:0]   key_code_r;
    logic                key_valid_r;
    logic                key_pressed_r;

    keypad_strobe_gen #(
        .scan_divider (scan_divider)
    ) u_strobe_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .strobe  (strobe_s)
    );

    // Two-stage synchronizer for the asynchronous row inputs (idle = pulled up).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_r <= 4'b1111;
            sync_r      <= 4'b1111;
        end else begin
            sync_meta_r <= rows_in;
            sync_r      <= sync_meta_r;
        end
    end

    assign row_act_s   = ~sync_r;
    assign row_sel_s   = row_priority(row_act_s);
    // While debouncing or held, only the row of the candidate key matters.
    assign cand_hit_s  = row_act_s[cand_code_r[1:0]];
    assign count_inc_s = count_r + 4'd1;
    assign col_next_s  = col_r + 2'd1;

    // Scan / debounce FSM; every state change is gated by the scan strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= SCAN;
            col_r         <= 2'd0;
            count_r       <= 4'd0;
            cand_code_r   <= 4'd0;
            cols_out_r    <= 4'b1110;
            key_code_r    <= 4'd0;
            key_valid_r   <= 1'b0;
            key_pressed_r <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            if (strobe_s) begin
                case (state_r)
                    SCAN: begin
                        if (row_act_s == 4'b0000) begin
                            col_r      <= col_next_s;
                            cols_out_r <= col_drive(col_next_s);
                        end else begin
                            cand_code_r <= {col_r, row_sel_s};
                            count_r     <= 4'd1;
                            state_r     <= DEB_PRESS;
                        end
                    end
                    DEB_PRESS: begin
                        if (cand_hit_s) begin
                            if (count_inc_s == DEB_LIMIT) begin
                                key_code_r    <= cand_code_r;
                                key_valid_r   <= 1'b1;
                                key_pressed_r <= 1'b1;
                                count_r       <= 4'd0;
                                state_r       <= HELD;
                            end else begin
                                count_r <= count_inc_s;
                            end
                        end else begin
                            count_r    <= 4'd0;
                            col_r      <= col_next_s;
                            cols_out_r <= col_drive(col_next_s);
                            state_r    <= SCAN;
                        end
                    end
                    HELD: begin
                        if (cand_hit_s) begin
                            count_r <= 4'd0;
                        end else if (count_inc_s == DEB_LIMIT) begin
                            key_pressed_r <= 1'b0;
                            count_r       <= 4'd0;
                            col_r         <= col_next_s;
                            cols_out_r    <= col_drive(col_next_s);
                            state_r       <= SCAN;
                        end else begin
                            count_r <= count_inc_s;
                        end
                    end
                    default: begin
                        // Unreachable encoding: recover into a clean scan.
                        state_r       <= SCAN;
                        count_r       <= 4'd0;
                        key_pressed_r <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign cols_out    = cols_out_r;
    assign key_code    = key_code_r;
    assign key_valid   = key_valid_r;
    assign key_pressed = key_pressed_r;

endmodule
